// File: rtl/uart_pkg.sv
// Purpose: shared UART types and constants (state encoding, word width).
// Latency: n/a (types only).
// Backpressure: n/a.
//
// Also intended for the transmit-side controller, so keep this free of
// receive-only details.
package uart_pkg;

  localparam int UART_DATA_BITS = 8;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } rx_state_t;

endpackage

// File: rtl/parity_checker.sv
// Purpose: odd-parity generator; o_parity is the bit that makes the total count of ones odd.
// Latency: combinational.
// Backpressure: none.
//
// Ports:
//   i_word   data word to check
//   o_parity 1 when i_word holds an even number of ones
module parity_checker
  import uart_pkg::*;
(
  input  logic [UART_DATA_BITS-1:0] i_word,
  output logic                      o_parity
);

  assign o_parity = ~(^i_word);

endmodule

// File: rtl/uart_rx_ctrl.sv
// Purpose: UART receiver: 2-flop sync, start detect, mid-bit sampling, 8N/8O1 framing.
// Latency: o_valid rises on the edge that commits the stop-bit sample.
// Backpressure: single-entry holding register; a frame finishing while it is full is dropped and flagged by o_overrun.
//
// Ports:
//   i_clk, i_rst                  clock, synchronous active-high reset
//   i_rx                          asynchronous serial line (idle high)
//   i_ready                       consumer accepts held word when i_ready && o_valid
//   o_data, o_valid               held word and its full flag
//   o_parity_err, o_frame_err     error flags of the held word
//   o_overrun                     1-cycle pulse when a finished frame is dropped
//   o_busy                        receiver FSM not idle
module uart_rx_ctrl
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 434,
  parameter bit PARITY_EN    = 1'b1
) (
  input  logic                      i_clk,
  input  logic                      i_rst,
  input  logic                      i_rx,
  input  logic                      i_ready,
  output logic [UART_DATA_BITS-1:0] o_data,
  output logic                      o_valid,
  output logic                      o_parity_err,
  output logic                      o_frame_err,
  output logic                      o_overrun,
  output logic                      o_busy
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int BW = $clog2(UART_DATA_BITS);
  localparam logic [CW-1:0] CNT_FULL = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] CNT_HALF = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(UART_DATA_BITS - 1);

  // Synchroniser and edge-detect flops reset to the idle-line level so that
  // leaving reset never looks like a start edge.
  logic rx_meta_q, rx_s_q, rx_prev_q;

  rx_state_t                 state_q, state_d;
  logic [CW-1:0]             cnt_q, cnt_d;
  logic [BW-1:0]             bitcnt_q, bitcnt_d;
  logic [UART_DATA_BITS-1:0] shreg_q, shreg_d;
  logic                      perr_q, perr_d;
  logic [UART_DATA_BITS-1:0] data_q, data_d;
  logic                      valid_q, valid_d;
  logic                      perr_out_q, perr_out_d;
  logic                      ferr_out_q, ferr_out_d;
  logic                      overrun_q, overrun_d;
  logic                      busy_q, busy_d;

  logic parity_exp;
  logic baud_tick;

  parity_checker u_parity_checker (
    .i_word   (shreg_q),
    .o_parity (parity_exp)
  );

  assign baud_tick = (cnt_q == '0);

  always_comb begin
    state_d    = state_q;
    cnt_d      = baud_tick ? cnt_q : cnt_q - CW'(1);
    bitcnt_d   = bitcnt_q;
    shreg_d    = shreg_q;
    perr_d     = perr_q;
    data_d     = data_q;
    valid_d    = valid_q;
    perr_out_d = perr_out_q;
    ferr_out_d = ferr_out_q;
    overrun_d  = 1'b0;

    if (valid_q && i_ready) begin
      valid_d = 1'b0;
    end

    case (state_q)
      IDLE: begin
        // Requires prev=1, so a line still low after a framing error is
        // ignored until it has been seen high again.
        if (rx_prev_q && !rx_s_q) begin
          state_d  = START;
          cnt_d    = CNT_HALF;
          bitcnt_d = '0;
          perr_d   = 1'b0;
        end
      end
      START: begin
        if (baud_tick) begin
          if (!rx_s_q) begin
            state_d = DATA;
            cnt_d   = CNT_FULL;
          end else begin
            state_d = IDLE;  // glitch shorter than half a bit
          end
        end
      end
      DATA: begin
        if (baud_tick) begin
          shreg_d  = {rx_s_q, shreg_q[UART_DATA_BITS-1:1]};
          cnt_d    = CNT_FULL;
          bitcnt_d = bitcnt_q + BW'(1);
          if (bitcnt_q == BIT_LAST) begin
            state_d = PARITY_EN ? PARITY : STOP;
          end
        end
      end
      PARITY: begin
        if (baud_tick) begin
          perr_d  = (rx_s_q != parity_exp);
          cnt_d   = CNT_FULL;
          state_d = STOP;
        end
      end
      STOP: begin
        if (baud_tick) begin
          state_d = IDLE;
          // Accept-and-replace in one cycle keeps o_valid high.
          if (!valid_q || i_ready) begin
            data_d     = shreg_q;
            perr_out_d = perr_q;
            ferr_out_d = !rx_s_q;
            valid_d    = 1'b1;
          end else begin
            overrun_d = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      rx_meta_q  <= 1'b1;
      rx_s_q     <= 1'b1;
      rx_prev_q  <= 1'b1;
      state_q    <= IDLE;
      cnt_q      <= '0;
      bitcnt_q   <= '0;
      shreg_q    <= '0;
      perr_q     <= 1'b0;
      data_q     <= '0;
      valid_q    <= 1'b0;
      perr_out_q <= 1'b0;
      ferr_out_q <= 1'b0;
      overrun_q  <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      rx_meta_q  <= i_rx;
      rx_s_q     <= rx_meta_q;
      rx_prev_q  <= rx_s_q;
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      bitcnt_q   <= bitcnt_d;
      shreg_q    <= shreg_d;
      perr_q     <= perr_d;
      data_q     <= data_d;
      valid_q    <= valid_d;
      perr_out_q <= perr_out_d;
      ferr_out_q <= ferr_out_d;
      overrun_q  <= overrun_d;
      busy_q     <= busy_d;
    end
  end

  assign o_data       = data_q;
  assign o_valid      = valid_q;
  assign o_parity_err = perr_out_q;
  assign o_frame_err  = ferr_out_q;
  assign o_overrun    = overrun_q;
  assign o_busy       = busy_q;

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Purpose: directed, table-driven bench for uart_rx_ctrl (16 clocks/bit, odd parity).
// Latency: n/a.
// Backpressure: exercises i_ready low to provoke overrun.
module tb_uart_rx_ctrl;
  localparam int N = 16;

  logic       clk = 1'b0;
  logic       i_rst, i_rx, i_ready;
  logic [7:0] o_data;
  logic       o_valid, o_parity_err, o_frame_err, o_overrun, o_busy;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  uart_rx_ctrl #(.CLKS_PER_BIT(N), .PARITY_EN(1'b1)) dut (
    .i_clk        (clk),
    .i_rst        (i_rst),
    .i_rx         (i_rx),
    .i_ready      (i_ready),
    .o_data       (o_data),
    .o_valid      (o_valid),
    .o_parity_err (o_parity_err),
    .o_frame_err  (o_frame_err),
    .o_overrun    (o_overrun),
    .o_busy       (o_busy)
  );

  typedef struct packed {
    logic [7:0] data;
    logic       perr;
    logic       ferr;
  } cap_t;

  // Words accepted by the consumer and overrun pulses, sampled mid-cycle.
  cap_t cap_q[$];
  int   ovr_cnt = 0;

  always @(negedge clk) begin
    if (!i_rst && o_valid && i_ready) cap_q.push_back({o_data, o_parity_err, o_frame_err});
    if (!i_rst && o_overrun) ovr_cnt++;
  end

  typedef struct {
    logic [7:0] data;
    logic       par;
    logic       stop;
    logic       exp_perr;
    logic       exp_ferr;
  } vec_t;

  vec_t vecs[6];

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic send_frame(input logic [7:0] d, input logic par, input logic stop,
                            input int tail_low);
    i_rx = 1'b0;
    tick(N);
    for (int i = 0; i < 8; i++) begin
      i_rx = d[i];
      tick(N);
    end
    i_rx = par;
    tick(N);
    i_rx = stop;
    tick(N);
    if (tail_low > 0) begin
      i_rx = 1'b0;
      tick(tail_low);
    end
    i_rx = 1'b1;
    tick(2 * N);
  endtask

  task automatic chk_word(input string name, input int idx, input logic [7:0] d,
                          input logic perr, input logic ferr);
    if (cap_q.size() <= idx) begin
      n_checks++;
      n_errors++;
      $display("FAIL %s: no word captured (have %0d, need index %0d)", name, cap_q.size(), idx);
    end else begin
      chk({name, ".data"}, 32'(cap_q[idx].data), 32'(d));
      chk({name, ".perr"}, 32'(cap_q[idx].perr), 32'(perr));
      chk({name, ".ferr"}, 32'(cap_q[idx].ferr), 32'(ferr));
    end
  endtask

  task automatic chk_idle_outputs(input string name, input logic [7:0] d);
    chk({name, ".data"},    32'(o_data), 32'(d));
    chk({name, ".valid"},   32'(o_valid), 0);
    chk({name, ".perr"},    32'(o_parity_err), 0);
    chk({name, ".ferr"},    32'(o_frame_err), 0);
    chk({name, ".overrun"}, 32'(o_overrun), 0);
    chk({name, ".busy"},    32'(o_busy), 0);
  endtask

  initial begin
    int base;
    int ovr0;

    //            data   par   stop  perr  ferr
    vecs[0] = '{8'hA5, 1'b1, 1'b1, 1'b0, 1'b0};  // 4 ones, correct parity
    vecs[1] = '{8'h07, 1'b1, 1'b1, 1'b1, 1'b0};  // 3 ones, parity should be 0
    vecs[2] = '{8'h00, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[3] = '{8'hFF, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[4] = '{8'h80, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[5] = '{8'h5A, 1'b0, 1'b1, 1'b1, 1'b0};  // 4 ones, parity should be 1

    i_rst   = 1'b1;
    i_rx    = 1'b1;
    i_ready = 1'b1;
    tick(3);
    chk_idle_outputs("reset", 8'h00);
    i_rst = 1'b0;
    tick(5);

    // Table-driven clean/parity frames with i_ready held high.
    for (int v = 0; v < 6; v++) begin
      base = cap_q.size();
      send_frame(vecs[v].data, vecs[v].par, vecs[v].stop, 0);
      chk($sformatf("vec%0d.count", v), 32'(cap_q.size() - base), 1);
      chk_word($sformatf("vec%0d", v), base, vecs[v].data, vecs[v].exp_perr, vecs[v].exp_ferr);
      chk($sformatf("vec%0d.valid_after", v), 32'(o_valid), 0);
    end

    // Framing error, line held low, then a clean frame after the line recovers.
    base = cap_q.size();
    send_frame(8'h3C, 1'b1, 1'b0, 40);
    send_frame(8'h01, 1'b0, 1'b1, 0);
    chk("ferr.count", 32'(cap_q.size() - base), 2);
    chk_word("ferr.w0", base, 8'h3C, 1'b0, 1'b1);
    chk_word("ferr.w1", base + 1, 8'h01, 1'b0, 1'b0);

    // 4-cycle glitch on the idle line.
    base = cap_q.size();
    i_rx = 1'b0;
    tick(4);
    i_rx = 1'b1;
    chk("glitch.busy_seen", 32'(o_busy), 1);
    tick(N / 2 + 4);
    chk("glitch.busy", 32'(o_busy), 0);
    chk("glitch.valid", 32'(o_valid), 0);
    chk("glitch.count", 32'(cap_q.size() - base), 0);

    // Overrun: consumer stalled across two frames.
    i_ready = 1'b0;
    ovr0 = ovr_cnt;
    send_frame(8'h11, 1'b1, 1'b1, 0);
    chk("ovr.valid1", 32'(o_valid), 1);
    chk("ovr.data1", 32'(o_data), 32'h11);
    chk("ovr.pulses_first", 32'(ovr_cnt - ovr0), 0);
    send_frame(8'h22, 1'b1, 1'b1, 0);
    chk("ovr.valid2", 32'(o_valid), 1);
    chk("ovr.data2", 32'(o_data), 32'h11);
    chk("ovr.pulses", 32'(ovr_cnt - ovr0), 1);
    base = cap_q.size();
    i_ready = 1'b1;
    tick(1);
    chk("ovr.valid_clear", 32'(o_valid), 0);
    chk_word("ovr.accepted", base, 8'h11, 1'b0, 1'b0);
    chk("ovr.accept_count", 32'(cap_q.size() - base), 1);

    // Reset in the middle of the data bits.
    base = cap_q.size();
    i_rx = 1'b0;
    tick(N);
    for (int i = 0; i < 3; i++) begin
      i_rx = (i % 2 == 0) ? 1'b1 : 1'b0;  // first bits of 0x55
      tick(N);
    end
    chk("rst.busy_before", 32'(o_busy), 1);
    i_rst = 1'b1;
    i_rx  = 1'b1;
    tick(1);
    chk_idle_outputs("rst", 8'h00);
    i_rst = 1'b0;
    tick(2 * N);
    chk("rst.no_word", 32'(cap_q.size() - base), 0);
    send_frame(8'hC3, 1'b1, 1'b1, 0);
    chk("rst.count", 32'(cap_q.size() - base), 1);
    chk_word("rst.C3", base, 8'hC3, 1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  // Hard stop in case a sequence ever stalls.
  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not reach the end, checks %0d", n_checks);
    $fatal(1, "timeout");
  end

endmodule
